// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline skid stage.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } pipe_state_e;

  localparam logic [15:0] NOP_INSTR_DEFAULT = 16'hE000;

endpackage

// File: rtl/pipe_perf_cnt.sv
// Saturating stall/bubble counters for pipe_stage_skid.
// Present in the build only when PIPE_PERF_CNT_EN is defined.
module pipe_perf_cnt (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dn_valid,
  input  logic        dn_ready,
  input  logic        hold,
  output logic [31:0] stall_cnt,
  output logic [31:0] bubble_cnt
);

  logic stall_evt;
  logic bubble_evt;

  assign stall_evt  = dn_valid & (hold | ~dn_ready);
  assign bubble_evt = ~dn_valid;

  // Flush is deliberately not an input: counters survive pipeline flushes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (stall_evt && (stall_cnt != 32'hFFFF_FFFF)) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      if (bubble_evt && (bubble_cnt != 32'hFFFF_FFFF)) begin
        bubble_cnt <= bubble_cnt + 32'd1;
      end
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Two-entry (main + skid) pipeline stage with registered up_ready and outputs.
// Define PIPE_PERF_CNT_EN to add stall_cnt/bubble_cnt performance counters.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int                 PC_W      = 16,
  parameter int                 INSTR_W   = 16,
  parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(NOP_INSTR_DEFAULT)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               up_valid,
  output logic               up_ready,
  input  logic [PC_W-1:0]    up_pc,
  input  logic [INSTR_W-1:0] up_instr,
  input  logic               flush,
  input  logic               hold,
  output logic               dn_valid,
  input  logic               dn_ready,
  output logic [PC_W-1:0]    dn_pc,
  output logic [INSTR_W-1:0] dn_instr
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [31:0]        stall_cnt,
  output logic [31:0]        bubble_cnt
`endif
);

  pipe_state_e        state_q, state_d;
  logic [PC_W-1:0]    main_pc_d;
  logic [INSTR_W-1:0] main_instr_d;
  logic [PC_W-1:0]    skid_pc_q;
  logic [INSTR_W-1:0] skid_instr_q;
  logic               load_skid;
  logic               accept;
  logic               pop;

  assign accept = up_valid & up_ready;
  assign pop    = dn_valid & dn_ready & ~hold;

  // dn_pc/dn_instr are the main entry itself; an empty stage parks them at 0/NOP.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path infers a latch.
    state_d      = state_q;
    main_pc_d    = dn_pc;
    main_instr_d = dn_instr;
    load_skid    = 1'b0;
    if (flush) begin
      state_d      = EMPTY;
      main_pc_d    = '0;
      main_instr_d = NOP_INSTR;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d      = ONE;
            main_pc_d    = up_pc;
            main_instr_d = up_instr;
          end
        end
        ONE: begin
          if (accept && pop) begin
            main_pc_d    = up_pc;
            main_instr_d = up_instr;
          end else if (accept) begin
            state_d   = TWO;
            load_skid = 1'b1;
          end else if (pop) begin
            state_d      = EMPTY;
            main_pc_d    = '0;
            main_instr_d = NOP_INSTR;
          end
        end
        TWO: begin
          if (pop) begin
            state_d      = ONE;
            main_pc_d    = skid_pc_q;
            main_instr_d = skid_instr_q;
          end
        end
        default: begin
          state_d      = EMPTY;
          main_pc_d    = '0;
          main_instr_d = NOP_INSTR;
        end
      endcase
    end
  end

  // up_ready and dn_valid are decoded from the next state so they leave a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      state_q  <= EMPTY;
      up_ready <= 1'b1;
      dn_valid <= 1'b0;
      dn_pc    <= '0;
      dn_instr <= NOP_INSTR;
    end else begin
      state_q  <= state_d;
      up_ready <= (state_d != TWO);
      dn_valid <= (state_d != EMPTY);
      dn_pc    <= main_pc_d;
      dn_instr <= main_instr_d;
    end
  end

  // NOTE: skid payload has no reset; it is only read in TWO, reached solely via a load.
  always_ff @(posedge clk) begin
    if (load_skid) begin
      skid_pc_q    <= up_pc;
      skid_instr_q <= up_instr;
    end
  end

`ifdef PIPE_PERF_CNT_EN
  pipe_perf_cnt u_perf_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .dn_valid   (dn_valid),
    .dn_ready   (dn_ready),
    .hold       (hold),
    .stall_cnt  (stall_cnt),
    .bubble_cnt (bubble_cnt)
  );
`else
  // Counter-free build: no extra ports or state.
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid against a queue-based FIFO model.
// Counter checks are compiled in when PIPE_PERF_CNT_EN is defined.
module tb_pipe_stage_skid;

  typedef struct {
    logic [15:0] pc;
    logic [15:0] instr;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        up_valid, up_ready;
  logic [15:0] up_pc, up_instr;
  logic        flush, hold;
  logic        dn_valid, dn_ready;
  logic [15:0] dn_pc, dn_instr;
`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cnt, bubble_cnt;
`endif

  beat_t       model_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [33:0] obs;

  assign obs = {up_ready, dn_valid, dn_pc, dn_instr};

  pipe_stage_skid dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .up_valid   (up_valid),
    .up_ready   (up_ready),
    .up_pc      (up_pc),
    .up_instr   (up_instr),
    .flush      (flush),
    .hold       (hold),
    .dn_valid   (dn_valid),
    .dn_ready   (dn_ready),
    .dn_pc      (dn_pc),
    .dn_instr   (dn_instr)
`ifdef PIPE_PERF_CNT_EN
    ,
    .stall_cnt  (stall_cnt),
    .bubble_cnt (bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Expected {up_ready, dn_valid, dn_pc, dn_instr} from the model's occupancy.
  function automatic logic [33:0] exp_vec();
    if (model_q.size() == 0) return {1'b1, 1'b0, 16'h0000, 16'hE000};
    return {(model_q.size() < 2), 1'b1, model_q[0].pc, model_q[0].instr};
  endfunction

  // Drive one cycle from a negedge, advance the model at the posedge, return at the next negedge.
  task automatic cycle(input logic v, input logic [15:0] pc, input logic [15:0] ins,
                       input logic rdy, input logic hld, input logic fl);
    bit acc, pp;
    beat_t b;
    up_valid = v;  up_pc = pc;  up_instr = ins;
    dn_ready = rdy; hold = hld;  flush = fl;
    acc = v && (model_q.size() < 2);
    pp  = (model_q.size() > 0) && rdy && !hld;
    @(posedge clk);
    if (fl) begin
      model_q.delete();
    end else begin
      if (pp) b = model_q.pop_front();
      if (acc) model_q.push_back('{pc, ins});
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (obs !== 34'({1'b1, 1'b0, 16'h0000, 16'hE000})) begin
      n_fail++;
      $display("FAIL reset_state: got %h expected %h", obs, {1'b1, 1'b0, 16'h0000, 16'hE000});
    end
    rst_n = 1'b1;
    cycle(1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (obs !== exp_vec()) begin
      n_fail++;
      $display("FAIL post_reset_idle: got %h expected %h", obs, exp_vec());
    end
  endtask

  task automatic test_stream();
    logic [15:0] pcs [3] = '{16'h0010, 16'h0012, 16'h0014};
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, pcs[i], 16'h1000 + 16'(i), 1'b1, 1'b0, 1'b0);
      n_checks++;
      if (obs !== exp_vec() || dn_pc !== pcs[i]) begin
        n_fail++;
        $display("FAIL stream_beat%0d: got %h expected %h", i, obs, exp_vec());
      end
    end
    cycle(1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (obs !== exp_vec()) begin
      n_fail++;
      $display("FAIL stream_drain: got %h expected %h", obs, exp_vec());
    end
  endtask

  task automatic test_hold();
    cycle(1'b1, 16'h0020, 16'h2020, 1'b1, 1'b1, 1'b0);
    cycle(1'b1, 16'h0022, 16'h2022, 1'b1, 1'b1, 1'b0);
    n_checks++;
    if (obs !== exp_vec() || up_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_full: got %h expected %h", obs, exp_vec());
    end
    // A third beat offered while full must be refused without disturbing the held pair.
    cycle(1'b1, 16'h0024, 16'h2024, 1'b1, 1'b1, 1'b0);
    n_checks++;
    if (obs !== exp_vec() || dn_pc !== 16'h0020) begin
      n_fail++;
      $display("FAIL hold_stable: got %h expected %h", obs, exp_vec());
    end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0);
      n_checks++;
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL hold_release%0d: got %h expected %h", i, obs, exp_vec());
      end
    end
  endtask

  task automatic test_flush();
    cycle(1'b1, 16'h0030, 16'h3030, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 16'h0032, 16'h3032, 1'b0, 1'b0, 1'b0);
    // Flush together with hold and an incoming beat: flush must win.
    cycle(1'b1, 16'h0034, 16'h3034, 1'b1, 1'b1, 1'b1);
    n_checks++;
    if (obs !== exp_vec() || obs !== 34'({1'b1, 1'b0, 16'h0000, 16'hE000})) begin
      n_fail++;
      $display("FAIL flush_empty: got %h expected %h", obs, exp_vec());
    end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0);
      n_checks++;
      if (dn_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL flush_no_beat%0d: got dn_valid=%b expected 0", i, dn_valid);
      end
    end
  endtask

  task automatic test_reset_mid();
    cycle(1'b1, 16'h0040, 16'h4040, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 16'h0042, 16'h4042, 1'b0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    model_q.delete();
    n_checks++;
    if (obs !== exp_vec()) begin
      n_fail++;
      $display("FAIL reset_midstream: got %h expected %h", obs, exp_vec());
    end
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b1, 16'h0044, 16'h4044, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (obs !== exp_vec()) begin
      n_fail++;
      $display("FAIL reset_resume: got %h expected %h", obs, exp_vec());
    end
    cycle(1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    int errs = 0;
    for (int i = 0; i < 10000; i++) begin
      cycle(1'($urandom_range(0, 99) < 60), 16'($urandom), 16'($urandom),
            1'($urandom_range(0, 99) < 60), 1'($urandom_range(0, 99) < 20),
            1'($urandom_range(0, 199) == 0));
      n_checks++;
      if (obs !== exp_vec()) begin
        n_fail++;
        errs++;
        if (errs <= 10) $display("FAIL random_cycle%0d: got %h expected %h", i, obs, exp_vec());
      end
    end
    for (int i = 0; i < 3; i++) cycle(1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (obs !== exp_vec() || dn_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL random_drain: got %h expected %h", obs, exp_vec());
    end
  endtask

`ifdef PIPE_PERF_CNT_EN
  task automatic test_perf_cnt();
    logic [31:0] s0, b0;
    cycle(1'b1, 16'h0050, 16'h5050, 1'b1, 1'b0, 1'b0);
    s0 = stall_cnt;
    for (int i = 0; i < 5; i++) cycle(1'b0, 16'h0, 16'h0, 1'b1, 1'b1, 1'b0);
    n_checks++;
    if (stall_cnt - s0 !== 32'd5) begin
      n_fail++;
      $display("FAIL stall_cnt: got %0d expected 5", stall_cnt - s0);
    end
    cycle(1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0);
    b0 = bubble_cnt;
    for (int i = 0; i < 4; i++) cycle(1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b1);
    n_checks++;
    if (bubble_cnt - b0 !== 32'd4) begin
      n_fail++;
      $display("FAIL bubble_cnt: got %0d expected 4", bubble_cnt - b0);
    end
  endtask
`endif

  initial begin
    rst_n = 1'b0; up_valid = 1'b0; up_pc = '0; up_instr = '0;
    flush = 1'b0; hold = 1'b0; dn_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_stream();
    test_hold();
    test_flush();
    test_reset_mid();
    test_random();
`ifdef PIPE_PERF_CNT_EN
    test_perf_cnt();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
